// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_port
// Summary  : Memory-mapped 8N1 UART transmitter with DATA/STATUS/DIV registers.
//            Define UART_TX_FIFO_EN for a DEPTH-entry FIFO, else one holding reg.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_port #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] data_wr,
    input  logic [3:0]  data_wr_en,
    output logic [31:0] data_rd,
    output logic        tx
);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned c_DEPTH = DEPTH;
`else
    // DEPTH is ignored here; the holding register gives an effective depth of one.
    localparam int unsigned c_DEPTH = DEPTH / DEPTH;
`endif
    localparam int unsigned     c_CW   = $clog2(c_DEPTH) + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [15:0]     div_q;
    logic [15:0]     div_lat_q;
    logic [15:0]     tick_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            ovf_q;
    logic [c_CW-1:0] count_q;
    logic [c_CW-1:0] count_d;

    logic       bus_wr, push_req, push_ok, pop;
    logic       full, empty, busy, ovf_clr, div_wr;
    logic [7:0] head;
    logic [3:0] occ;
    logic       unused_bits;

    assign bus_wr   = sel && (data_wr_en != 4'b0000);
    assign push_req = bus_wr && (addr == 2'd0) && data_wr_en[0];
    assign ovf_clr  = bus_wr && (addr == 2'd1) && data_wr_en[0] && data_wr[3];
    assign div_wr   = bus_wr && (addr == 2'd2) && (data_wr_en[1:0] == 2'b11);
    assign full     = (count_q == c_FULL);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    // A pop frees the slot in the same cycle, so a push into a full queue still lands.
    assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && (tick_q == 16'd0)));
    assign push_ok  = push_req && (!full || pop);
    assign occ      = 4'(count_q);
    assign unused_bits = ^data_wr[31:16];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + c_CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DIV_RESET;
        end else begin
            count_q <= count_d;
            if (push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (div_wr) begin
                div_q <= (data_wr[15:0] == 16'd0) ? 16'd1 : data_wr[15:0];
            end
        end
    end

`ifdef UART_TX_FIFO_EN
    localparam int unsigned c_PW = $clog2(c_DEPTH);
    logic [7:0]      mem_q [0:c_DEPTH-1];
    logic [c_PW-1:0] wptr_q;
    logic [c_PW-1:0] rptr_q;

    assign head = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + c_PW'(1);
            if (pop)     rptr_q <= rptr_q + c_PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= data_wr[7:0];
    end
`else
    logic [7:0] hold_q;

    assign head = hold_q;

    always_ff @(posedge clk) begin
        if (push_ok) hold_q <= data_wr[7:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            div_lat_q <= DIV_RESET;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q   <= S_START;
                        tx_q      <= 1'b0;
                        shift_q   <= head;
                        div_lat_q <= div_q;
                        tick_q    <= div_q - 16'd1;
                    end
                end
                S_START: begin
                    if (tick_q == 16'd0) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= 3'd0;
                        tick_q  <= div_lat_q - 16'd1;
                    end else begin
                        tick_q <= tick_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tick_q == 16'd0) begin
                        tick_q <= div_lat_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        tick_q <= tick_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (tick_q != 16'd0) begin
                        tick_q <= tick_q - 16'd1;
                    end else if (pop) begin
                        state_q   <= S_START;
                        tx_q      <= 1'b0;
                        shift_q   <= head;
                        div_lat_q <= div_q;
                        tick_q    <= div_q - 16'd1;
                    end else begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx = tx_q;

    always_comb begin
        data_rd = '0;
        if (sel) begin
            case (addr)
                2'd1:    data_rd = {24'd0, occ, ovf_q, empty, full, busy};
                2'd2:    data_rd = {16'd0, div_q};
                default: data_rd = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_port
// Summary  : Directed + randomized bench for uart_tx_port with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_port;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_FIFO_EN
    localparam int EFFD = DEPTH;
`else
    localparam int EFFD = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] data_wr = 32'd0;
    logic [3:0]  data_wr_en = 4'd0;
    logic [31:0] data_rd;
    logic        tx;

    uart_tx_port #(.DEPTH(DEPTH), .DIV_RESET(16'd868)) dut (
        .clk(clk), .rst(rst), .sel(sel), .addr(addr), .data_wr(data_wr),
        .data_wr_en(data_wr_en), .data_rd(data_rd), .tx(tx)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: bytes accepted but not yet started, with the cycle they were written.
    byte unsigned exp_q[$];
    int           push_cyc_q[$];
    int           model_div = 868;
    bit           mon_en = 1'b0;
    bit           in_frame = 1'b0;
    bit           start_due;
    bit           mon_exp;
    int           pos, frame_div, mon_bit;
    logic [7:0]   frame_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A byte written in cycle c must start its frame no earlier and no later than
    // cycle c+2 once the line is free; frames are 10 bit periods of the latched DIV.
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            in_frame = 1'b0;
        end else if (in_frame) begin
            mon_bit = pos / frame_div;
            if (mon_bit == 0)      mon_exp = 1'b0;
            else if (mon_bit == 9) mon_exp = 1'b1;
            else                   mon_exp = frame_byte[mon_bit-1];
            chk("tx_frame_bit", {31'd0, tx}, {31'd0, mon_exp});
            pos++;
            if (pos == 10 * frame_div) in_frame = 1'b0;
        end else begin
            start_due = (exp_q.size() > 0) && (push_cyc_q[0] <= cyc - 2);
            chk("tx_idle_or_start", {31'd0, tx}, {31'd0, !start_due});
            if (start_due) begin
                frame_byte = exp_q.pop_front();
                void'(push_cyc_q.pop_front());
                frame_div  = model_div;
                pos        = 1;
                in_frame   = 1'b1;
            end
        end
    end

    task automatic bus_wr(input logic s, input logic [1:0] a, input logic [31:0] d, input logic [3:0] en);
        sel = s; addr = a; data_wr = d; data_wr_en = en;
        @(posedge clk); #1;
        sel = 1'b0; data_wr_en = 4'd0;
    endtask

    task automatic put(input logic [7:0] b, input bit accept);
        logic [31:0] r;
        r = $urandom();
        if (accept) begin
            exp_q.push_back(b);
            push_cyc_q.push_back(cyc);
        end
        bus_wr(1'b1, 2'd0, {r[31:8], b}, {r[2:0], 1'b1});
    endtask

    task automatic set_div(input logic [15:0] d);
        logic [31:0] r;
        r = $urandom();
        model_div = (d == 16'd0) ? 1 : int'(d);
        bus_wr(1'b1, 2'd2, {r[31:16], d}, {r[3:2], 2'b11});
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        sel = 1'b1; addr = a; data_wr_en = 4'd0;
        @(negedge clk);
        v = data_rd;
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_within_budget", {31'd0, (exp_q.size() == 0 && !in_frame)}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, v1, v2;
        int busy_n, n, g, w;

        repeat (3) @(posedge clk);
        #1; rst = 1'b0; mon_en = 1'b1;

        rd(2'd1, v); chk("status_reset", v, 32'h4);
        rd(2'd2, v); chk("div_reset", v, 32'd868);
        chk("tx_reset", {31'd0, tx}, 32'd1);
        rd(2'd0, v); chk("data_reads_zero", v, 32'd0);
        rd(2'd3, v); chk("reserved_reads_zero", v, 32'd0);
        sel = 1'b0; addr = 2'd2;
        @(negedge clk); chk("unselected_read_zero", data_rd, 32'd0);
        @(posedge clk); #1;

        set_div(16'd4);
        put(8'hA5, 1'b1);
        busy_n = 0;
        for (int i = 0; i < 60; i++) begin
            rd(2'd1, v);
            if (i == 0) v1 = v;
            if (i == 1) v2 = v;
            busy_n += int'(v[0]);
        end
        chk("status_byte_queued", v1, {24'd0, 4'd1, 1'b0, 1'b0, (EFFD == 1), 1'b0});
        chk("status_frame_started", v2, 32'h5);
        chk("busy_cycle_count", busy_n, 32'd40);
        chk("status_after_frame", v, 32'h4);
        wait_idle(100);

        set_div(16'd2);
        for (int i = 0; i <= EFFD; i++) put(8'(i + 1), 1'b1);
        put(8'hEE, 1'b0);
        rd(2'd1, v); chk("status_overflow_full", v, {24'd0, 4'(EFFD), 4'b1011});
        bus_wr(1'b1, 2'd1, 32'h0, 4'b0001);
        rd(2'd1, v); chk("overflow_kept_without_bit3", v, {24'd0, 4'(EFFD), 4'b1011});
        bus_wr(1'b1, 2'd1, 32'h8, 4'b0001);
        rd(2'd1, v); chk("overflow_cleared", v, {24'd0, 4'(EFFD), 4'b0011});
        wait_idle(400);

        set_div(16'd0);
        rd(2'd2, v); chk("div_zero_stored_as_one", v, 32'd1);
        bus_wr(1'b1, 2'd2, 32'h1234, 4'b0001);
        rd(2'd2, v); chk("div_low_enable_only_ignored", v, 32'd1);
        bus_wr(1'b1, 2'd2, 32'h00FF_0003, 4'b1110);
        rd(2'd2, v); chk("div_high_enables_ignored", v, 32'd1);
        bus_wr(1'b0, 2'd2, 32'h7, 4'b1111);
        rd(2'd2, v); chk("div_unselected_ignored", v, 32'd1);
        bus_wr(1'b1, 2'd3, 32'hFFFF_FFFF, 4'b1111);
        rd(2'd3, v); chk("reserved_write_ignored", v, 32'd0);
        bus_wr(1'b0, 2'd0, 32'h5A, 4'b0001);
        repeat (20) begin @(posedge clk); #1; end
        rd(2'd1, v); chk("unselected_data_ignored", v, 32'h4);
        put(8'h3C, 1'b1);
        wait_idle(100);

        set_div(16'd3);
        put(8'($urandom), 1'b1);
        w = 0;
        while (!(in_frame && pos >= 4) && w < 100) begin @(posedge clk); #1; w++; end
        chk("reach_mid_frame", {31'd0, in_frame}, 32'd1);
        set_div(16'd1);
        put(8'($urandom), 1'b1);
        wait_idle(200);

        set_div(16'd4);
        put(8'($urandom), 1'b1);
        put(8'($urandom), 1'b1);
        w = 0;
        while (!(in_frame && pos >= 8 && pos < 36) && w < 200) begin @(posedge clk); #1; w++; end
        chk("reach_data_phase", {31'd0, in_frame}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        push_cyc_q.delete();
        model_div = 868;
        @(posedge clk); #1;
        rst = 1'b0; sel = 1'b1; addr = 2'd1;
        @(negedge clk);
        chk("tx_high_after_reset", {31'd0, tx}, 32'd1);
        chk("status_after_reset", data_rd, 32'h4);
        @(posedge clk); #1; sel = 1'b0;
        rd(2'd2, v); chk("div_after_reset", v, 32'd868);
        repeat (60) begin @(posedge clk); #1; end
        rd(2'd1, v); chk("status_no_frame_after_reset", v, 32'h4);

        for (int burst = 0; burst < 6; burst++) begin
            set_div(16'($urandom_range(1, 4)));
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                g = $urandom_range(0, 2);
                repeat (g) begin @(posedge clk); #1; end
                w = 0;
                while (exp_q.size() >= EFFD && w < 400) begin @(posedge clk); #1; w++; end
                chk("fifo_space_available", {31'd0, (exp_q.size() < EFFD)}, 32'd1);
                put(8'($urandom), 1'b1);
            end
            wait_idle(600);
        end
        rd(2'd1, v); chk("status_final", v, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter peripheral on the SoC data bus, alongside RAM, ROM and the LED register. The CPU writes bytes into a small transmit FIFO and polls a status register. A serializer drains the FIFO onto `tx` as 8N1 frames at a programmable bit period. The SoC decodes the peripheral's 16-byte window and drives `sel`. Read data is combinational, so it merges into the CPU's `data_rd` mux exactly like the other bus slaves.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `DIV_RESET`, 16'd868: bit period in clk cycles after reset (115200 baud at 100 MHz).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sel` in 1: address falls in this peripheral's window.
- `addr` in 2: word offset, `data_addr[3:2]`.
- `data_wr` in 32: CPU write data.
- `data_wr_en` in 4: CPU byte write enables.
- `data_rd` out 32: combinational read data; 0 when `sel`=0.
- `tx` out 1: serial line, idle high.

## Operation
- Register map, by word offset:
  - 0 DATA: write pushes `data_wr[7:0]` if `data_wr_en[0]`. Reads return 0.
  - 1 STATUS (read):
    - bit0 busy (frame in progress)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[7:4] occupancy count
    - other bits 0
  - 1 STATUS (write): `data_wr_en[0]` with `data_wr[3]`=1 clears overflow.
  - 2 DIV: R/W bit period, bits[15:0]. A write requires `data_wr_en[1:0]`=2'b11 and is ignored otherwise. A written value of 0 is stored as 1.
  - 3: reserved. Reads return 0; writes are ignored.
- Serializer FSM:
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head, latch DIV, go to START.
  - START: `tx`=0 for one bit period.
  - DATA: 8 bit periods, LSB first.
  - STOP: `tx`=1 for one bit period, then go to IDLE.
  - Each bit period is exactly the latched DIV value in cycles. A DIV write mid-frame affects only the next frame.
- FIFO behaviour:
  - Push when full: the byte is dropped, overflow is set, and count is unchanged.
  - Push and pop in the same cycle when full: the push is accepted and count is unchanged.
  - Push and pop in the same cycle when empty: impossible, because the pop only occurs when the FIFO was non-empty at the preceding edge.
  - Read/write pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Write acceptance: a write is any cycle with `sel`=1 and `data_wr_en`≠0. Writes with `sel`=0 are ignored.

## Timing
- Reset values:
  - `tx`=1, FSM=IDLE, FIFO empty (count 0), overflow=0, DIV=`DIV_RESET`.
  - `data_rd` follows the reset state: STATUS reads 32'h4.
- Reset mid-frame: `tx` returns high on the cycle after the reset edge and queued bytes are discarded.
- Register writes update state at the `clk` edge where they are sampled. STATUS reflects the write in the next cycle.
- Latency from a DATA write into an empty, idle FIFO:
  - FSM enters START at edge +1.
  - `tx` falls in the cycle after that edge.
- Back-to-back frames: STOP ends and the next START begins with no idle gap when the FIFO is non-empty.
- Full frame duration is 10×DIV cycles.
- busy=1 from START entry through the last STOP cycle inclusive.

## Configuration
- `UART_TX_FIFO_EN` defined: FIFO of `DEPTH` entries, as described above.
- `UART_TX_FIFO_EN` undefined:
  - Single holding register; `DEPTH` is ignored and effective depth is 1.
  - full = holding register occupied; count is 0 or 1.
  - Overflow, wrap and same-cycle rules apply with depth 1.

## Test plan
- Reset, then read STATUS: 32'h4. Read DIV: 868. `tx`=1.
- Write DIV=4, write DATA=8'hA5:
  - `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - busy reads 1 for 40 cycles, then STATUS = 32'h4.
- DIV=2, write 5 bytes 0x01..0x05 in consecutive cycles (DEPTH=4, FIFO enabled):
  - All 5 are accepted because the first pop frees a slot.
  - Write a 6th byte while full: overflow=1, the byte is dropped.
  - Output is 0x01..0x05 with no gaps.
  - Write STATUS with 0x8: overflow clears.
- Write DIV=0: reads back 1. Write DIV with `data_wr_en`=4'b0001: DIV unchanged.
- Assert `rst` for 1 cycle during the DATA phase of a frame: `tx`=1 next cycle, STATUS=32'h4, no further frame.
- Build without `UART_TX_FIFO_EN`, DIV=2:
  - Write 0x11 and 0x22 in consecutive cycles: both are sent.
  - A third write while the holding register is occupied sets overflow.
